// File: rtl/cnn_mac_pipe.sv
// Three-stage signed x unsigned multiply-accumulate for CNN inner products.
// Windows are framed by first/last flags or by an internal term counter; the accumulator saturates or wraps.
module cnn_mac_pipe #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 6,
  parameter int ACC_WIDTH = 24,
  parameter int USE_CNT   = 0,
  parameter int LEN       = 25,
  parameter int SAT       = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_ovf
);

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int S_WIDTH   = ACC_WIDTH + 1;
  localparam int CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Stage 1: operand capture and window tagging.
  logic                 tag_first;
  logic                 tag_last;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 v1_q, f1_q, l1_q;
  logic [A_WIDTH-1:0]   a1_q;
  logic [B_WIDTH-1:0]   b1_q;

  // Stage 2: exact product, sign-extended one bit past the accumulator.
  logic signed [P_WIDTH-1:0] a_ext;
  logic signed [P_WIDTH-1:0] b_ext;
  logic signed [P_WIDTH-1:0] prod;
  logic signed [S_WIDTH-1:0] p2_d, p2_q;
  logic                      v2_q, f2_q, l2_q;

  // Stage 3: accumulator and reported window.
  logic signed [S_WIDTH-1:0]   base;
  logic signed [S_WIDTH-1:0]   sum;
  logic                        ovf_now;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                        ovf_d, ovf_q;
  logic                        out_valid_q;
  logic [ACC_WIDTH-1:0]        acc_out_q;
  logic                        acc_ovf_q;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tag_first = in_first;
    tag_last  = in_last;
    cnt_d     = cnt_q;
    if (USE_CNT != 0) begin
      tag_first = (cnt_q == '0);
      tag_last  = (cnt_q == CNT_LAST);
      if (in_valid) begin
        cnt_d = tag_last ? '0 : cnt_q + CNT_ONE;
      end
    end
  end

  // b is a magnitude: zero-extend before the signed multiply.
  assign a_ext = P_WIDTH'($signed(a1_q));
  assign b_ext = P_WIDTH'({1'b0, b1_q});
  assign prod  = a_ext * b_ext;
  assign p2_d  = S_WIDTH'(prod);

  always_comb begin
    base    = f2_q ? '0 : S_WIDTH'(acc_q);
    sum     = base + p2_q;
    ovf_now = (sum[S_WIDTH-1] != sum[ACC_WIDTH-1]);
    acc_d   = sum[ACC_WIDTH-1:0];
    if (ovf_now && (SAT != 0)) begin
      acc_d = sum[S_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
    ovf_d = (f2_q ? 1'b0 : ovf_q) | ovf_now;
  end

  // NOTE: operand and product registers carry no reset; the reset valid bits already mask them.
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      a1_q <= in_a;
      b1_q <= in_b;
      p2_q <= p2_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      v2_q        <= 1'b0;
      f2_q        <= 1'b0;
      l2_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
    end else if (ce) begin
      cnt_q       <= cnt_d;
      v1_q        <= in_valid;
      f1_q        <= tag_first;
      l1_q        <= tag_last;
      v2_q        <= v1_q;
      f2_q        <= f1_q;
      l2_q        <= l1_q;
      out_valid_q <= v2_q & l2_q;
      if (v2_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
      if (v2_q && l2_q) begin
        acc_out_q <= acc_d;
        acc_ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Scoreboard bench for cnn_mac_pipe: a saturating and a wrapping flag-framed instance share stimulus,
// and a counter-framed instance (LEN=4) has its own valid.
module tb_cnn_mac_pipe;

  localparam int AW   = 14;
  localparam int BW   = 6;
  localparam int ACCW = 24;
  localparam int CLEN = 4;
  localparam longint ACC_MAX = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACCW - 1));

  typedef struct {
    longint due;
    longint acc_s;
    bit     ovf_s;
    longint acc_w;
    bit     ovf_w;
  } exp_t;

  logic            ap_clk;
  logic            ap_rst_n;
  logic            ce;
  logic            in_valid;
  logic            cnt_valid;
  logic [AW-1:0]   in_a;
  logic [BW-1:0]   in_b;
  logic            in_first;
  logic            in_last;
  logic            ov_s, ovf_s, ov_w, ovf_w, ov_c, ovf_c;
  logic [ACCW-1:0] acc_s, acc_w, acc_c;
  logic [3*(ACCW+2)-1:0] outs_now, outs_snap;

  exp_t   sb[$];
  exp_t   sb_c[$];
  exp_t   mon_e;
  int     pass_cnt  = 0;
  int     total_cnt = 0;
  longint en_cnt    = 0;
  bit     edge_en   = 1'b0;
  bit     edge_rst  = 1'b1;

  longint m_acc_s, m_acc_w, m_acc_c;
  bit     m_ovf_s, m_ovf_w, m_ovf_c;
  int     m_cnt;

  cnn_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .USE_CNT(0), .LEN(25), .SAT(1)) dut_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .out_valid(ov_s), .acc_out(acc_s), .acc_ovf(ovf_s));

  cnn_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .USE_CNT(0), .LEN(25), .SAT(0)) dut_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .out_valid(ov_w), .acc_out(acc_w), .acc_ovf(ovf_w));

  cnn_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .USE_CNT(1), .LEN(CLEN), .SAT(1)) dut_cnt (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(cnt_valid), .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .out_valid(ov_c), .acc_out(acc_c), .acc_ovf(ovf_c));

  assign outs_now = {ov_s, acc_s, ovf_s, ov_w, acc_w, ovf_w, ov_c, acc_c, ovf_c};

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Record what each rising edge did; inputs only change on the falling edge.
  always @(posedge ap_clk) begin
    edge_rst = !ap_rst_n;
    edge_en  = ap_rst_n && ce;
    if (edge_en) en_cnt++;
  end

  always @(negedge ap_clk) begin
    if (!edge_rst && edge_en) begin
      if (ov_s) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_out: out_valid=1 acc_out=%0d, required no output", $signed(acc_s));
        end else begin
          mon_e = sb.pop_front();
          total_cnt++;
          if (en_cnt !== mon_e.due) $display("FAIL latency: out at enabled edge %0d, required %0d", en_cnt, mon_e.due);
          else pass_cnt++;
          total_cnt++;
          if (longint'($signed(acc_s)) !== mon_e.acc_s) $display("FAIL acc_sat: got %0d, required %0d", $signed(acc_s), mon_e.acc_s);
          else pass_cnt++;
          total_cnt++;
          if (ovf_s !== mon_e.ovf_s) $display("FAIL ovf_sat: got %0b, required %0b", ovf_s, mon_e.ovf_s);
          else pass_cnt++;
          total_cnt++;
          if (ov_w !== 1'b1 || longint'($signed(acc_w)) !== mon_e.acc_w || ovf_w !== mon_e.ovf_w)
            $display("FAIL acc_wrap: got valid=%0b acc=%0d ovf=%0b, required valid=1 acc=%0d ovf=%0b",
                     ov_w, $signed(acc_w), ovf_w, mon_e.acc_w, mon_e.ovf_w);
          else pass_cnt++;
        end
      end else if (sb.size() != 0 && sb[0].due <= en_cnt) begin
        total_cnt++;
        $display("FAIL missing_out: no out_valid at edge %0d, required acc_out=%0d", en_cnt, sb[0].acc_s);
        void'(sb.pop_front());
      end
      if (ov_c) begin
        if (sb_c.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_cnt_out: out_valid=1 acc_out=%0d, required no output", $signed(acc_c));
        end else begin
          mon_e = sb_c.pop_front();
          total_cnt++;
          if (en_cnt !== mon_e.due || longint'($signed(acc_c)) !== mon_e.acc_s || ovf_c !== mon_e.ovf_s)
            $display("FAIL cnt_window: got edge=%0d acc=%0d ovf=%0b, required edge=%0d acc=%0d ovf=%0b",
                     en_cnt, $signed(acc_c), ovf_c, mon_e.due, mon_e.acc_s, mon_e.ovf_s);
          else pass_cnt++;
        end
      end else if (sb_c.size() != 0 && sb_c[0].due <= en_cnt) begin
        total_cnt++;
        $display("FAIL missing_cnt_out: no out_valid at edge %0d, required acc_out=%0d", en_cnt, sb_c[0].acc_s);
        void'(sb_c.pop_front());
      end
    end else if (!edge_rst) begin
      total_cnt++;
      if (outs_now !== outs_snap) $display("FAIL ce_freeze: outputs %h, required unchanged %h", outs_now, outs_snap);
      else pass_cnt++;
    end
    outs_snap = outs_now;
  end

  // Reference accumulate step, carried in 64-bit arithmetic.
  task automatic mac_step(input longint acc, input bit ovf, input longint p, input bit first, input bit sat,
                          output longint acc_n, output bit ovf_n);
    longint s;
    longint w;
    s     = (first ? 64'sd0 : acc) + p;
    ovf_n = first ? 1'b0 : ovf;
    acc_n = s;
    if (s > ACC_MAX || s < ACC_MIN) begin
      ovf_n = 1'b1;
      if (sat) begin
        acc_n = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
      end else begin
        w = s & 64'hFF_FFFF;
        if (w > ACC_MAX) w = w - 64'h100_0000;
        acc_n = w;
      end
    end
  endtask

  task automatic model_reset();
    m_acc_s = 0; m_acc_w = 0; m_acc_c = 0;
    m_ovf_s = 0; m_ovf_w = 0; m_ovf_c = 0;
    m_cnt   = 0;
  endtask

  // Present one term and hold it until an enabled edge accepts it, then update the model.
  task automatic send(input bit to_cnt, input int a, input int b, input bit f, input bit l, input bit rnd_ce);
    bit     ce_bit;
    bit     mf;
    bit     ml;
    int     tries;
    longint p;
    exp_t   e;
    tries = 0;
    do begin
      ce_bit    = (rnd_ce && tries < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
      ce        = ce_bit;
      in_valid  = !to_cnt;
      cnt_valid = to_cnt;
      in_a      = AW'(a);
      in_b      = BW'(b);
      in_first  = f;
      in_last   = l;
      tries++;
      @(negedge ap_clk);
    end while (!ce_bit);
    in_valid  = 1'b0;
    cnt_valid = 1'b0;
    p = longint'(a) * longint'(b);
    if (to_cnt) begin
      mf    = (m_cnt == 0);
      ml    = (m_cnt == CLEN - 1);
      m_cnt = ml ? 0 : m_cnt + 1;
      mac_step(m_acc_c, m_ovf_c, p, mf, 1'b1, m_acc_c, m_ovf_c);
      if (ml) begin
        e = '{due: en_cnt + 2, acc_s: m_acc_c, ovf_s: m_ovf_c, acc_w: 0, ovf_w: 1'b0};
        sb_c.push_back(e);
      end
    end else begin
      mac_step(m_acc_s, m_ovf_s, p, f, 1'b1, m_acc_s, m_ovf_s);
      mac_step(m_acc_w, m_ovf_w, p, f, 1'b0, m_acc_w, m_ovf_w);
      if (l) begin
        e = '{due: en_cnt + 2, acc_s: m_acc_s, ovf_s: m_ovf_s, acc_w: m_acc_w, ovf_w: m_ovf_w};
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    cnt_valid = 1'b0;
    ce        = 1'b1;
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic drain(input bit rnd_ce);
    int budget;
    budget    = 60;
    in_valid  = 1'b0;
    cnt_valid = 1'b0;
    while ((sb.size() != 0 || sb_c.size() != 0) && budget > 0) begin
      ce = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge ap_clk);
      #1;
      budget--;
    end
    total_cnt++;
    if (sb.size() != 0 || sb_c.size() != 0) begin
      $display("FAIL drain_timeout: %0d windows still pending, required 0", sb.size() + sb_c.size());
      sb.delete();
      sb_c.delete();
    end else pass_cnt++;
    idle(3);
  endtask

  task automatic check_zero_outputs(input string tag);
    #1;
    total_cnt++;
    if (outs_now !== '0) $display("FAIL %s: outputs %h, required all zero", tag, outs_now);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ce = 1'b0; in_valid = 1'b1; cnt_valid = 1'b1;
    in_a = 14'h1abc; in_b = 6'h2a; in_first = 1'b1; in_last = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_zero_outputs("reset_state");
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    send(1'b0, -3, 5, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_extreme();
    send(1'b0, -8192, 63, 1'b1, 1'b1, 1'b0);
    send(1'b0, 8191, 63, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_counter();
    for (int k = 1; k <= 4; k++) send(1'b1, k, 2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send(1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 25; k++) send(1'b0, -8192, 63, k == 0, k == 24, 1'b0);
    for (int k = 1; k <= 3; k++) send(1'b0, k, 1, k == 1, k == 3, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    send(1'b0, 10, 2, 1'b1, 1'b0, 1'b0);
    idle(2);
    send(1'b0, -3, 4, 1'b0, 1'b1, 1'b0);
    send(1'b0, 7, 7, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1, 1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 2, 2, 1'b0, 1'b1, 1'b0);
    send(1'b0, -100, 50, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_ce_random();
    for (int k = 1; k <= 9; k++) send(1'b0, k, 1, k == 1, k == 9, 1'b1);
    drain(1'b1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) send(1'b0, 100, 1, k == 0, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    ce       = 1'b1;
    @(negedge ap_clk);
    check_zero_outputs("reset_mid_outputs");
    model_reset();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) send(1'b0, 2, 3, k == 0, k == 4, 1'b0);
    drain(1'b0);
  endtask

  initial begin
    ap_rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; cnt_valid = 1'b0;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
    @(negedge ap_clk);
    test_reset();
    test_single();
    test_extreme();
    test_counter();
    test_saturate();
    test_back_to_back();
    test_ce_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
